// File: rtl/note_lane_engine_if.sv
// rtl/note_lane_engine_if.sv - control, player-input and render/score signal bundle for note_lane_engine
interface note_lane_engine_if #(
  parameter int NUM_LANES  = 3,
  parameter int VIEW_DEPTH = 4,
  parameter int SCORE_W    = 8,
  parameter int COMBO_W    = 6
) ();
  logic                            clear_i;
  logic                            load_en_i;
  logic [NUM_LANES-1:0]            load_col_i;
  logic                            start_i;
  logic                            step_i;
  logic [NUM_LANES-1:0]            note_in_i;
  logic [NUM_LANES*VIEW_DEPTH-1:0] view_o;
  logic [NUM_LANES-1:0]            hits_o;
  logic [NUM_LANES-1:0]            misses_o;
  logic [SCORE_W-1:0]              score_o;
  logic [COMBO_W-1:0]              combo_o;
  logic                            song_done_o;
  logic [1:0]                      state_o;

  modport slave (
    input  clear_i, load_en_i, load_col_i, start_i, step_i, note_in_i,
    output view_o, hits_o, misses_o, score_o, combo_o, song_done_o, state_o
  );

  modport master (
    output clear_i, load_en_i, load_col_i, start_i, step_i, note_in_i,
    input  view_o, hits_o, misses_o, score_o, combo_o, song_done_o, state_o
  );
endinterface

// File: rtl/note_lane_engine.sv
// rtl/note_lane_engine.sv - scrolling multi-lane note song with hit-line scoring and combo tracking
// Optional macro COMBO_MULT_EN: score increment scaled by 1 + min(combo/8, 3).
module note_lane_engine #(
  parameter int NUM_LANES  = 3,
  parameter int VIEW_DEPTH = 4,
  parameter int SONG_LEN   = 64,
  parameter int SCORE_W    = 8,
  parameter int COMBO_W    = 6
) (
  input logic               clock_i,
  input logic               reset_i,
  note_lane_engine_if.slave bus
);
  localparam int PTR_W     = $clog2(SONG_LEN + 1);
  localparam int AW        = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
  localparam int VW        = NUM_LANES * VIEW_DEPTH;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;
  localparam int COMBO_MAX = (1 << COMBO_W) - 1;
  localparam logic [PTR_W-1:0] SONG_END = PTR_W'(SONG_LEN);
  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_LANES-1:0] song_q [SONG_LEN];
  logic                 song_we;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     len_q, len_d;
  logic [NUM_LANES-1:0] press_q, press_d;
  logic [NUM_LANES-1:0] hits_q, hits_d;
  logic [NUM_LANES-1:0] misses_q, misses_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [COMBO_W-1:0]   combo_q, combo_d;
  logic                 done_q, done_d;
  logic [VW-1:0]        view_q, view_d;

  logic [NUM_LANES-1:0] col, pressed, hit, miss;
  int                   hit_cnt, score_inc, score_sum, combo_sum;
  logic                 win_load;
  logic [PTR_W-1:0]     win_base, win_len;
  logic [PTR_W:0]       widx;

  always_ff @(posedge clock_i) begin
    if (reset_i || bus.clear_i) begin
      for (int i = 0; i < SONG_LEN; i++) song_q[i] <= '0;
    end else if (song_we) begin
      song_q[wr_ptr_q[AW-1:0]] <= bus.load_col_i;
    end
  end

  // Hit-line evaluation; a press in the step cycle itself still counts.
  always_comb begin
    col     = song_q[rd_ptr_q[AW-1:0]];
    pressed = press_q | bus.note_in_i;
    hit     = col & pressed;
    miss    = col & ~pressed;
    hit_cnt = 0;
    for (int l = 0; l < NUM_LANES; l++) hit_cnt += int'(hit[l]);
`ifdef COMBO_MULT_EN
    score_inc = hit_cnt * (1 + ((int'(combo_q) >= 24) ? 3 : int'(combo_q) / 8));
`else
    score_inc = hit_cnt;
`endif
    score_sum = int'(score_q) + score_inc;
    combo_sum = int'(combo_q) + hit_cnt;
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    press_d  = (state_q == S_PLAY) ? pressed : press_q;
    hits_d   = '0;
    misses_d = '0;
    score_d  = score_q;
    combo_d  = combo_q;
    done_d   = 1'b0;
    view_d   = view_q;
    song_we  = 1'b0;
    win_load = 1'b0;
    win_base = rd_ptr_q;
    win_len  = len_q;
    widx     = '0;

    if (bus.clear_i) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      len_d    = '0;
      press_d  = '0;
      score_d  = '0;
      combo_d  = '0;
      view_d   = '0;
    end else if (state_q == S_PLAY && bus.step_i) begin
      hits_d   = hit;
      misses_d = miss;
      press_d  = '0;
      score_d  = (score_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(score_sum);
      if (|miss) begin
        combo_d = '0;
      end else if (|hit) begin
        combo_d = (combo_sum > COMBO_MAX) ? COMBO_W'(COMBO_MAX) : COMBO_W'(combo_sum);
      end
      if (rd_ptr_q == len_q - ONE) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q + ONE;
        win_load = 1'b1;
        win_base = rd_ptr_q + ONE;
      end
    end else if (bus.start_i && (state_q == S_LOAD || state_q == S_DONE) && wr_ptr_q != '0) begin
      state_d  = S_PLAY;
      len_d    = wr_ptr_q;
      rd_ptr_d = '0;
      press_d  = '0;
      score_d  = '0;
      combo_d  = '0;
      win_load = 1'b1;
      win_base = '0;
      win_len  = wr_ptr_q;
    end else if (bus.load_en_i && (state_q == S_IDLE || state_q == S_LOAD) && wr_ptr_q < SONG_END) begin
      song_we  = 1'b1;
      wr_ptr_d = wr_ptr_q + ONE;
      state_d  = S_LOAD;
    end

    // Columns past the end of the song render as background.
    if (win_load) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        for (int d = 0; d < VIEW_DEPTH; d++) begin
          widx = {1'b0, win_base} + (PTR_W + 1)'(d);
          view_d[l*VIEW_DEPTH+d] = (widx < {1'b0, win_len}) ? song_q[widx[AW-1:0]][l] : 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      press_q  <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      score_q  <= '0;
      combo_q  <= '0;
      done_q   <= 1'b0;
      view_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      press_q  <= press_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      score_q  <= score_d;
      combo_q  <= combo_d;
      done_q   <= done_d;
      view_q   <= view_d;
    end
  end

  assign bus.view_o      = view_q;
  assign bus.hits_o      = hits_q;
  assign bus.misses_o    = misses_q;
  assign bus.score_o     = score_q;
  assign bus.combo_o     = combo_q;
  assign bus.song_done_o = done_q;
  assign bus.state_o     = state_q;
endmodule

// File: tb/tb_note_lane_engine.sv
// tb/tb_note_lane_engine.sv - randomized self-checking bench for note_lane_engine
module tb_note_lane_engine;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   sc_m;
  int   cb_m;
  logic [2:0] tune[$];

  note_lane_engine_if #(.SCORE_W(8)) bus_a ();
  note_lane_engine_if #(.SCORE_W(6)) bus_b ();

  note_lane_engine #(.SCORE_W(8)) dut_a (.clock_i(clk), .reset_i(rst), .bus(bus_a));
  note_lane_engine #(.SCORE_W(6)) dut_b (.clock_i(clk), .reset_i(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mult(input int cb);
`ifdef COMBO_MULT_EN
    return 1 + ((cb / 8 > 3) ? 3 : cb / 8);
`else
    return 1;
`endif
  endfunction

  function automatic logic [11:0] exp_view(input int rd);
    logic [11:0] v;
    v = '0;
    for (int l = 0; l < 3; l++)
      for (int d = 0; d < 4; d++)
        if (rd + d < tune.size()) v[l*4+d] = tune[rd+d][l];
    return v;
  endfunction

  task automatic load_a(input string tag);
    foreach (tune[i]) begin
      bus_a.load_en_i = 1'b1;
      bus_a.load_col_i = tune[i];
      tick();
    end
    bus_a.load_en_i = 1'b0;
    bus_a.load_col_i = '0;
    total++; if (bus_a.state_o !== 2'd1) begin bad++; $display("FAIL %s load_state got=%0d want=1", tag, bus_a.state_o); end
  endtask

  task automatic start_a(input string tag);
    bus_a.start_i = 1'b1;
    tick();
    bus_a.start_i = 1'b0;
    sc_m = 0;
    cb_m = 0;
    total++; if (bus_a.state_o !== 2'd2) begin bad++; $display("FAIL %s start_state got=%0d want=2", tag, bus_a.state_o); end
    total++; if (bus_a.view_o !== exp_view(0)) begin bad++; $display("FAIL %s start_view got=%b want=%b", tag, bus_a.view_o, exp_view(0)); end
    total++; if ({bus_a.score_o, bus_a.combo_o} !== 14'd0) begin bad++; $display("FAIL %s start_score got=%0d/%0d want=0/0", tag, bus_a.score_o, bus_a.combo_o); end
  endtask

  task automatic clear_a(input string tag);
    bus_a.clear_i = 1'b1;
    tick();
    bus_a.clear_i = 1'b0;
    total++; if ({bus_a.state_o, bus_a.view_o, bus_a.score_o, bus_a.combo_o} !== 28'd0) begin
      bad++; $display("FAIL %s clear got state=%0d view=%h score=%0d combo=%0d want all 0", tag, bus_a.state_o, bus_a.view_o, bus_a.score_o, bus_a.combo_o);
    end
  endtask

  task automatic play_step(input logic [2:0] acc, input logic [2:0] p_step, input int rd, input string tag);
    logic [2:0]  c, pr, eh, em;
    logic [11:0] ev;
    logic [1:0]  es;
    int          n;
    bit          last;
    bus_a.note_in_i = p_step;
    bus_a.step_i = 1'b1;
    tick();
    bus_a.step_i = 1'b0;
    bus_a.note_in_i = '0;
    c  = tune[rd];
    pr = acc | p_step;
    eh = c & pr;
    em = c & ~pr;
    n  = $countones(eh);
    sc_m = sc_m + n * mult(cb_m);
    if (sc_m > 255) sc_m = 255;
    if (em != 3'b000) cb_m = 0;
    else begin
      cb_m = cb_m + n;
      if (cb_m > 63) cb_m = 63;
    end
    last = (rd == tune.size() - 1);
    ev = exp_view(last ? rd : rd + 1);
    es = last ? 2'd3 : 2'd2;
    total++; if (bus_a.hits_o !== eh) begin bad++; $display("FAIL %s hits col%0d got=%b want=%b", tag, rd, bus_a.hits_o, eh); end
    total++; if (bus_a.misses_o !== em) begin bad++; $display("FAIL %s misses col%0d got=%b want=%b", tag, rd, bus_a.misses_o, em); end
    total++; if (bus_a.score_o !== 8'(sc_m)) begin bad++; $display("FAIL %s score col%0d got=%0d want=%0d", tag, rd, bus_a.score_o, sc_m); end
    total++; if (bus_a.combo_o !== 6'(cb_m)) begin bad++; $display("FAIL %s combo col%0d got=%0d want=%0d", tag, rd, bus_a.combo_o, cb_m); end
    total++; if (bus_a.song_done_o !== last) begin bad++; $display("FAIL %s song_done col%0d got=%b want=%b", tag, rd, bus_a.song_done_o, last); end
    total++; if (bus_a.state_o !== es) begin bad++; $display("FAIL %s state col%0d got=%0d want=%0d", tag, rd, bus_a.state_o, es); end
    total++; if (bus_a.view_o !== ev) begin bad++; $display("FAIL %s view col%0d got=%b want=%b", tag, rd, bus_a.view_o, ev); end
    tick();
    total++; if ({bus_a.hits_o, bus_a.misses_o, bus_a.song_done_o} !== 7'd0) begin
      bad++; $display("FAIL %s pulse_width col%0d got hits=%b misses=%b done=%b want 0", tag, rd, bus_a.hits_o, bus_a.misses_o, bus_a.song_done_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++; if (bus_a.state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", bus_a.state_o); end
    total++; if (bus_a.view_o !== 12'd0) begin bad++; $display("FAIL reset_view got=%h want=0", bus_a.view_o); end
    total++; if ({bus_a.score_o, bus_a.combo_o} !== 14'd0) begin bad++; $display("FAIL reset_score got=%0d/%0d want=0/0", bus_a.score_o, bus_a.combo_o); end
    total++; if ({bus_a.hits_o, bus_a.misses_o, bus_a.song_done_o} !== 7'd0) begin bad++; $display("FAIL reset_pulses got=%b want=0", {bus_a.hits_o, bus_a.misses_o, bus_a.song_done_o}); end
    total++; if ({bus_b.state_o, bus_b.score_o, bus_b.combo_o} !== 14'd0) begin bad++; $display("FAIL reset_b got=%h want=0", {bus_b.state_o, bus_b.score_o, bus_b.combo_o}); end
    rst = 1'b0;
  endtask

  task automatic test_start_idle();
    bus_a.start_i = 1'b1;
    tick();
    bus_a.start_i = 1'b0;
    total++; if (bus_a.state_o !== 2'd0) begin bad++; $display("FAIL idle_start got=%0d want=0", bus_a.state_o); end
    bus_a.step_i = 1'b1;
    tick();
    bus_a.step_i = 1'b0;
    total++; if ({bus_a.state_o, bus_a.hits_o, bus_a.misses_o} !== 8'd0) begin bad++; $display("FAIL idle_step got=%h want=0", {bus_a.state_o, bus_a.hits_o, bus_a.misses_o}); end
  endtask

  task automatic test_directed();
    tune = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b111};
    clear_a("dir");
    load_a("dir");
    start_a("dir");
    total++; if (bus_a.view_o !== 12'b0100_0010_0001) begin bad++; $display("FAIL dir_view0 got=%b want=010000100001", bus_a.view_o); end
    for (int i = 0; i < 5; i++) play_step(3'b000, tune[i], i, "dir");
    total++; if ({bus_a.score_o, bus_a.combo_o} !== {8'd6, 6'd6}) begin bad++; $display("FAIL dir_final got=%0d/%0d want=6/6", bus_a.score_o, bus_a.combo_o); end
    tick();
    total++; if (bus_a.state_o !== 2'd3 || bus_a.score_o !== 8'd6 || bus_a.view_o !== exp_view(4)) begin
      bad++; $display("FAIL dir_done_hold got state=%0d score=%0d view=%b want 3/6/%b", bus_a.state_o, bus_a.score_o, bus_a.view_o, exp_view(4));
    end
  endtask

  task automatic test_miss();
    start_a("miss");
    for (int i = 0; i < 5; i++) play_step(3'b000, (i == 1) ? 3'b000 : tune[i], i, "miss");
    total++; if ({bus_a.score_o, bus_a.combo_o} !== {8'd5, 6'd4}) begin bad++; $display("FAIL miss_final got=%0d/%0d want=5/4", bus_a.score_o, bus_a.combo_o); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      clear_a("rnd");
      tune.delete();
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) tune.push_back(3'($urandom));
      load_a("rnd");
      start_a("rnd");
      for (int i = 0; i < tune.size(); i++) begin
        logic [2:0] acc, r, p;
        acc = '0;
        repeat ($urandom_range(0, 2)) begin
          r = 3'($urandom);
          bus_a.note_in_i = r;
          acc = acc | r;
          tick();
        end
        bus_a.note_in_i = '0;
        p = ($urandom_range(0, 2) == 0) ? tune[i] : 3'($urandom);
        play_step(acc, p, i, "rnd");
      end
    end
  endtask

  task automatic test_mid_reset();
    tune = '{3'b011, 3'b101, 3'b110, 3'b111};
    clear_a("mrst");
    load_a("mrst");
    start_a("mrst");
    play_step(3'b000, 3'b011, 0, "mrst");
    play_step(3'b000, 3'b001, 1, "mrst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({bus_a.state_o, bus_a.view_o, bus_a.score_o, bus_a.combo_o, bus_a.hits_o, bus_a.misses_o, bus_a.song_done_o} !== 35'd0) begin
      bad++; $display("FAIL mid_reset got state=%0d view=%h score=%0d combo=%0d want all 0", bus_a.state_o, bus_a.view_o, bus_a.score_o, bus_a.combo_o);
    end
    bus_a.start_i = 1'b1;
    tick();
    bus_a.start_i = 1'b0;
    total++; if (bus_a.state_o !== 2'd0) begin bad++; $display("FAIL reset_noload_start got=%0d want=0", bus_a.state_o); end
  endtask

  task automatic test_combo_mult();
    tune.delete();
    repeat (12) tune.push_back(3'b001);
    load_a("mult");
    start_a("mult");
    for (int i = 0; i < 12; i++) play_step(3'b000, 3'b001, i, "mult");
`ifdef COMBO_MULT_EN
    total++; if (bus_a.score_o !== 8'd16) begin bad++; $display("FAIL mult_score got=%0d want=16", bus_a.score_o); end
`else
    total++; if (bus_a.score_o !== 8'd12) begin bad++; $display("FAIL mult_score got=%0d want=12", bus_a.score_o); end
`endif
  endtask

  task automatic test_saturation();
    int          sc, cb;
    logic [11:0] ev;
    for (int i = 0; i < 65; i++) begin
      bus_b.load_en_i = 1'b1;
      bus_b.load_col_i = 3'b111;
      tick();
    end
    bus_b.load_en_i = 1'b0;
    total++; if (bus_b.state_o !== 2'd1) begin bad++; $display("FAIL sat_load_state got=%0d want=1", bus_b.state_o); end
    bus_b.start_i = 1'b1;
    tick();
    bus_b.start_i = 1'b0;
    total++; if (bus_b.view_o !== 12'hFFF) begin bad++; $display("FAIL sat_view0 got=%h want=fff", bus_b.view_o); end
    sc = 0;
    cb = 0;
    for (int i = 0; i < 64; i++) begin
      int nx;
      bus_b.note_in_i = 3'b111;
      bus_b.step_i = 1'b1;
      tick();
      bus_b.step_i = 1'b0;
      bus_b.note_in_i = '0;
      sc = sc + 3 * mult(cb);
      if (sc > 63) sc = 63;
      cb = cb + 3;
      if (cb > 63) cb = 63;
      nx = (i == 63) ? 63 : i + 1;
      ev = '0;
      for (int l = 0; l < 3; l++)
        for (int d = 0; d < 4; d++)
          ev[l*4+d] = (nx + d < 64);
      total++; if (bus_b.score_o !== 6'(sc) || bus_b.combo_o !== 6'(cb)) begin
        bad++; $display("FAIL sat_score step%0d got=%0d/%0d want=%0d/%0d", i, bus_b.score_o, bus_b.combo_o, sc, cb);
      end
      total++; if (bus_b.song_done_o !== (i == 63) || bus_b.state_o !== ((i == 63) ? 2'd3 : 2'd2)) begin
        bad++; $display("FAIL sat_end step%0d got done=%b state=%0d want done=%b", i, bus_b.song_done_o, bus_b.state_o, (i == 63));
      end
      total++; if (bus_b.view_o !== ev) begin bad++; $display("FAIL sat_view step%0d got=%h want=%h", i, bus_b.view_o, ev); end
      tick();
    end
    total++; if ({bus_b.score_o, bus_b.combo_o} !== {6'd63, 6'd63}) begin bad++; $display("FAIL sat_final got=%0d/%0d want=63/63", bus_b.score_o, bus_b.combo_o); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    sc_m = 0;
    cb_m = 0;
    rst = 1'b1;
    bus_a.clear_i = 1'b0; bus_a.load_en_i = 1'b0; bus_a.load_col_i = '0;
    bus_a.start_i = 1'b0; bus_a.step_i = 1'b0; bus_a.note_in_i = '0;
    bus_b.clear_i = 1'b0; bus_b.load_en_i = 1'b0; bus_b.load_col_i = '0;
    bus_b.start_i = 1'b0; bus_b.step_i = 1'b0; bus_b.note_in_i = '0;
    tick();
    test_reset();
    test_start_idle();
    test_directed();
    test_miss();
    test_random();
    test_mid_reset();
    test_combo_mult();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
